// File: rtl/to_upper_arbiter_if.sv
// Bundle of requester, converter and result signals for to_upper_arbiter.
// Optional conv_count signal is present only when TOUPPER_STATS_EN is defined.
// master: the arbiter side; slave: the environment (requesters, converter, sink).
interface to_upper_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] conv_in;
    logic [7:0] conv_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;
    logic       busy;
`ifdef TOUPPER_STATS_EN
    logic [15:0] conv_count;
`endif

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, conv_out, out_ready,
        output req0_ready, req1_ready, conv_in, out_valid, out_data, out_src, busy
`ifdef TOUPPER_STATS_EN
        , output conv_count
`endif
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, conv_out, out_ready,
        input  req0_ready, req1_ready, conv_in, out_valid, out_data, out_src, busy
`ifdef TOUPPER_STATS_EN
        , input conv_count
`endif
    );
endinterface

// File: rtl/to_upper_arbiter.sv
// Round-robin sharing controller for the gate-level upper-case converter.
// Grants one of two requesters, holds the converter input for SETTLE_CYCLES,
// captures the converter output and presents it with a valid/ready handshake.
// Optional macro TOUPPER_STATS_EN adds a saturating count of changed characters.
module to_upper_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    to_upper_arbiter_if.master   bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic [7:0]       conv_in_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             out_src_q;
    logic             busy_q;

    logic             grant0_d;
    logic             grant1_d;

    // Combinational grant: alternate on a tie, otherwise serve whoever is valid.
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_d = last_grant_q;
                grant1_d = ~last_grant_q;
            end else begin
                grant0_d = bus.req0_valid;
                grant1_d = bus.req1_valid;
            end
        end
    end

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            conv_in_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant0_d || grant1_d) begin
                        conv_in_q    <= grant1_d ? bus.req1_data : bus.req0_data;
                        out_src_q    <= grant1_d;
                        last_grant_q <= grant1_d;
                        cnt_q        <= CNT_W'(SETTLE_CYCLES - 1);
                        busy_q       <= 1'b1;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        out_data_q  <= bus.conv_out;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = grant0_d;
    assign bus.req1_ready = grant1_d;
    assign bus.conv_in    = conv_in_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.busy       = busy_q;

`ifdef TOUPPER_STATS_EN
    logic [15:0] conv_count_q;

    // Count delivered results that differ from the converter input; saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_count_q <= '0;
        end else if (out_valid_q && bus.out_ready && (out_data_q != conv_in_q)
                     && (conv_count_q != '1)) begin
            conv_count_q <= conv_count_q + 16'd1;
        end
    end

    assign bus.conv_count = conv_count_q;
`endif

endmodule

// File: tb/tb_to_upper_arbiter.sv
// Directed self-checking bench for to_upper_arbiter with SETTLE_CYCLES=3.
// A behavioural upper-case converter stands in for the gate-level one.
// Stats checks are compiled only when TOUPPER_STATS_EN is defined.
module tb_to_upper_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    to_upper_arbiter_if bus ();

    assign bus.conv_out = (bus.conv_in >= 8'h61 && bus.conv_in <= 8'h7A)
                          ? (bus.conv_in - 8'h20) : bus.conv_in;

    to_upper_arbiter #(.SETTLE_CYCLES(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold > 0 keeps out_ready low that many HOLD cycles
    // while both requesters clamour for a grant.
    task automatic run_one(input string tag,
                           input logic v0, input logic [7:0] d0,
                           input logic v1, input logic [7:0] d1,
                           input logic [7:0] exp_d, input logic exp_s,
                           input int hold);
        logic [7:0] in_d;
        int cyc;
        in_d = exp_s ? d1 : d0;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.out_ready  = 1'b1;
        #1;
        check({tag, " rdy0"}, 32'(bus.req0_ready), 32'(!exp_s));
        check({tag, " rdy1"}, 32'(bus.req1_ready), 32'(exp_s));
        tick;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            check({tag, " busy"}, 32'(bus.busy), 32'd1);
            check({tag, " conv_in"}, 32'(bus.conv_in), 32'(in_d));
            tick;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd4);
        check({tag, " data"}, 32'(bus.out_data), 32'(exp_d));
        check({tag, " src"}, 32'(bus.out_src), 32'(exp_s));
        if (hold > 0) begin
            bus.out_ready  = 1'b0;
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick;
                check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, " hold data"}, 32'(bus.out_data), 32'(exp_d));
                check({tag, " hold conv_in"}, 32'(bus.conv_in), 32'(in_d));
                check({tag, " hold rdy0"}, 32'(bus.req0_ready), 32'd0);
                check({tag, " hold rdy1"}, 32'(bus.req1_ready), 32'd0);
            end
            bus.out_ready  = 1'b1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        tick;
        check({tag, " done valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " done busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    logic [7:0] pass_vec [5] = '{8'h7B, 8'h40, 8'hEB, 8'h7F, 8'h41};

    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.out_ready  = 1'b0;
        do_reset;

        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst conv_in", 32'(bus.conv_in), 32'h00);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'h00);
        check("rst out_src", 32'(bus.out_src), 32'd0);

        run_one("single", 1'b1, 8'h61, 1'b0, 8'h00, 8'h41, 1'b0, 0);

        do_reset;
        run_one("tie1", 1'b1, 8'h7A, 1'b1, 8'h6D, 8'h5A, 1'b0, 0);
        run_one("tie2", 1'b1, 8'h7A, 1'b1, 8'h6D, 8'h4D, 1'b1, 0);
        run_one("tie3", 1'b1, 8'h7A, 1'b1, 8'h6D, 8'h5A, 1'b0, 0);
        run_one("tie4", 1'b1, 8'h7A, 1'b1, 8'h6D, 8'h4D, 1'b1, 0);

        for (int i = 0; i < 5; i++)
            run_one($sformatf("pass%0d", i), 1'b0, 8'h00, 1'b1, pass_vec[i],
                    pass_vec[i], 1'b1, 0);

        run_one("bp", 1'b1, 8'h71, 1'b0, 8'h00, 8'h51, 1'b0, 5);

        // Reset one cycle into SETTLE; last_grant is 0 here so a later tie
        // only goes to req0 if reset restored last_grant.
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h6D;
        bus.out_ready  = 1'b1;
        #1;
        check("abort rdy0", 32'(bus.req0_ready), 32'd1);
        tick;
        bus.req0_valid = 1'b0;
        check("abort settle busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort conv_in", 32'(bus.conv_in), 32'h00);
        for (int i = 0; i < 6; i++) begin
            tick;
            check("abort no output", 32'(bus.out_valid), 32'd0);
        end
        run_one("after abort", 1'b1, 8'h62, 1'b1, 8'h63, 8'h42, 1'b0, 0);

`ifdef TOUPPER_STATS_EN
        do_reset;
        check("stats rst", 32'(bus.conv_count), 32'h0000);
        run_one("st a", 1'b1, 8'h61, 1'b0, 8'h00, 8'h41, 1'b0, 0);
        run_one("st H", 1'b1, 8'h48, 1'b0, 8'h00, 8'h48, 1'b0, 0);
        run_one("st z", 1'b1, 8'h7A, 1'b0, 8'h00, 8'h5A, 1'b0, 0);
        run_one("st 0", 1'b1, 8'h30, 1'b0, 8'h00, 8'h30, 1'b0, 0);
        check("stats count", 32'(bus.conv_count), 32'd2);
        dut.conv_count_q = 16'hFFFE;
        run_one("sat1", 1'b1, 8'h61, 1'b0, 8'h00, 8'h41, 1'b0, 0);
        check("stats ffff", 32'(bus.conv_count), 32'hFFFF);
        run_one("sat2", 1'b1, 8'h61, 1'b0, 8'h00, 8'h41, 1'b0, 0);
        check("stats sat", 32'(bus.conv_count), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
